// File: rtl/cpu_pkg.sv
// Shared definitions for the execution unit: opcodes, FSM states, flag layout
// and small opcode-decode helpers.
package cpu_pkg;

    localparam logic [7:0] OP_NOP = 8'h00;
    localparam logic [7:0] OP_LDI = 8'h01;
    localparam logic [7:0] OP_ADD = 8'h02;
    localparam logic [7:0] OP_SUB = 8'h03;
    localparam logic [7:0] OP_AND = 8'h04;
    localparam logic [7:0] OP_OR  = 8'h05;
    localparam logic [7:0] OP_XOR = 8'h06;
    localparam logic [7:0] OP_MUL = 8'h07;
    localparam logic [7:0] OP_ST  = 8'h08;
    localparam logic [7:0] OP_SHL = 8'h09;

    // Bit positions inside the {N,C,Z} flag vector.
    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_MUL  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    function automatic logic op_is_alu(input logic [7:0] op);
        return (op == OP_ADD) || (op == OP_SUB) || (op == OP_AND) ||
               (op == OP_OR)  || (op == OP_XOR) || (op == OP_SHL);
    endfunction

    function automatic logic op_is_legal(input logic [7:0] op);
        return op <= OP_SHL;
    endfunction

    function automatic logic [2:0] pack_flags(input logic n, input logic c, input logic z);
        logic [2:0] f;
        f         = '0;
        f[FLAG_N] = n;
        f[FLAG_C] = c;
        f[FLAG_Z] = z;
        return f;
    endfunction

endpackage

// File: rtl/cpu_exec_unit_if.sv
// Sequencer-to-execution-unit bus: command/operand controls in, result and
// status pulses out.
interface cpu_exec_unit_if #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16
) ();

    logic [NUM_REGS-1:0] reg_enable;
    logic [7:0]          opcode;
    logic                a_enable;
    logic                b_enable;
    logic                start;
    logic [DATA_W-1:0]   imm;
    logic [DATA_W-1:0]   result;
    logic [2:0]          flags;
    logic                busy;
    logic                done;
    logic                err;

    modport master (
        output reg_enable, opcode, a_enable, b_enable, start, imm,
        input  result, flags, busy, done, err
    );

    modport slave (
        input  reg_enable, opcode, a_enable, b_enable, start, imm,
        output result, flags, busy, done, err
    );

endinterface

// File: rtl/cpu_regfile.sv
// General-purpose register file: one-hot select shared by the single write
// port and the combinational read port.
module cpu_regfile #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REGS-1:0] sel_i,
    input  logic                we_i,
    input  logic [DATA_W-1:0]   wdata_i,
    output logic [DATA_W-1:0]   rdata_o
);

    logic [DATA_W-1:0] regs_q [NUM_REGS];

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= '0;
            end
        end else if (we_i) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (sel_i[i]) begin
                    regs_q[i] <= wdata_i;
                end
            end
        end
    end

    // Read returns pre-edge contents, so a same-cycle load sees the old value.
    always_comb begin
        rdata_o = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (sel_i[i]) begin
                rdata_o = rdata_o | regs_q[i];
            end
        end
    end

endmodule

// File: rtl/cpu_exec_unit.sv
// Execution unit: operand latches, single-cycle ALU, shift-add multiplier and
// the issue/complete FSM in front of the register file.
//
//   state   | meaning
//   IDLE    | accepts loads, LDI/ST and start
//   EXEC    | single-cycle ALU op in flight (busy)
//   MUL     | shift-add multiply, one iteration per cycle (busy)
//   DONE    | done pulse, back to IDLE next cycle
module cpu_exec_unit import cpu_pkg::*; #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 16
) (
    input  logic           clk,
    input  logic           reset,
    cpu_exec_unit_if.slave bus
);

    localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    state_t                  state_q;
    logic [7:0]              op_q;
    logic [DATA_W-1:0]       a_q, b_q;
    logic [DATA_W-1:0]       a_d, b_d;
    logic [DATA_W-1:0]       result_q;
    logic [2:0]              flags_q;
    logic                    busy_q, done_q, err_q;
    logic [2*DATA_W-1:0]     acc_q, acc_d, mcand_q;
    logic [DATA_W-1:0]       mplier_q;
    logic [CNT_W-1:0]        cnt_q;

    logic                    is_idle;
    logic                    sel_onehot;
    logic                    op_ldi, op_st;
    logic                    access_req;
    logic                    err_d;
    logic                    rf_we;
    logic [DATA_W-1:0]       rf_wdata;
    logic [DATA_W-1:0]       rf_rdata;

    logic [DATA_W:0]         sum;
    logic [DATA_W-1:0]       alu_res;
    logic                    alu_c;
    logic [DATA_W-1:0]       mul_res;
    logic                    mul_c;

    assign is_idle    = (state_q == ST_IDLE);
    assign sel_onehot = (bus.reg_enable != '0) &&
                        ((bus.reg_enable & (bus.reg_enable - NUM_REGS'(1))) == '0);
    assign op_ldi     = (bus.opcode == OP_LDI);
    assign op_st      = (bus.opcode == OP_ST);
    assign access_req = bus.a_enable | bus.b_enable | (bus.start & (op_ldi | op_st));
    assign err_d      = is_idle & ((access_req & ~sel_onehot) |
                                   (bus.start & ~op_is_legal(bus.opcode)));

    assign rf_we    = is_idle & bus.start & sel_onehot & (op_ldi | op_st);
    assign rf_wdata = op_ldi ? bus.imm : result_q;

    assign a_d = (is_idle && bus.a_enable && sel_onehot) ? rf_rdata : a_q;
    assign b_d = (is_idle && bus.b_enable && sel_onehot) ? rf_rdata : b_q;

    cpu_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS)
    ) u_regfile (
        .clk     (clk),
        .reset   (reset),
        .sel_i   (bus.reg_enable),
        .we_i    (rf_we),
        .wdata_i (rf_wdata),
        .rdata_o (rf_rdata)
    );

    always_comb begin
        sum     = '0;
        alu_res = '0;
        alu_c   = 1'b0;
        case (op_q)
            OP_ADD: begin
                sum     = {1'b0, a_q} + {1'b0, b_q};
                alu_res = sum[DATA_W-1:0];
                alu_c   = sum[DATA_W];
            end
            OP_SUB: begin
                alu_res = a_q - b_q;
                alu_c   = (a_q < b_q);
            end
            OP_AND: alu_res = a_q & b_q;
            OP_OR:  alu_res = a_q | b_q;
            OP_XOR: alu_res = a_q ^ b_q;
            OP_SHL: begin
                alu_res = {a_q[DATA_W-2:0], 1'b0};
                alu_c   = a_q[DATA_W-1];
            end
            default: ;
        endcase
    end

    assign acc_d   = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_res = acc_d[DATA_W-1:0];
    assign mul_c   = |acc_d[2*DATA_W-1:DATA_W];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            op_q     <= OP_NOP;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            flags_q  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            done_q <= 1'b0;
            err_q  <= err_d;
            case (state_q)
                ST_IDLE: begin
                    if (bus.start) begin
                        op_q <= bus.opcode;
                        if (op_is_alu(bus.opcode)) begin
                            state_q <= ST_EXEC;
                            busy_q  <= 1'b1;
                        end else if (bus.opcode == OP_MUL) begin
                            state_q  <= ST_MUL;
                            busy_q   <= 1'b1;
                            acc_q    <= '0;
                            mcand_q  <= {{DATA_W{1'b0}}, a_d};
                            mplier_q <= b_d;
                            cnt_q    <= CNT_W'(DATA_W - 1);
                        end
                    end
                end
                ST_EXEC: begin
                    result_q <= alu_res;
                    flags_q  <= pack_flags(alu_res[DATA_W-1], alu_c, alu_res == '0);
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= ST_DONE;
                end
                ST_MUL: begin
                    acc_q    <= acc_d;
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_q >> 1;
                    cnt_q    <= cnt_q - CNT_W'(1);
                    if (cnt_q == '0) begin
                        result_q <= mul_res;
                        flags_q  <= pack_flags(mul_res[DATA_W-1], mul_c, mul_res == '0);
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                        state_q  <= ST_DONE;
                    end
                end
                ST_DONE: state_q <= ST_IDLE;
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.flags  = flags_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.err    = err_q;

endmodule

// File: tb/tb_cpu_exec_unit.sv
// Bench for cpu_exec_unit: directed vector table, multi-cycle corner
// sequences and randomized ops against an arithmetic reference model.
module tb_cpu_exec_unit;

    localparam int DW = 8;
    localparam int NR = 16;

    localparam logic [7:0] O_NOP = 8'h00, O_LDI = 8'h01, O_ADD = 8'h02, O_SUB = 8'h03,
                           O_AND = 8'h04, O_OR  = 8'h05, O_XOR = 8'h06, O_MUL = 8'h07,
                           O_ST  = 8'h08, O_SHL = 8'h09;

    typedef struct {
        string      name;
        logic [7:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] res;
        logic [2:0] flg;
        int         lat;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_exec_unit_if #(.DATA_W(DW), .NUM_REGS(NR)) bus ();

    cpu_exec_unit #(.DATA_W(DW), .NUM_REGS(NR)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] m_regs [NR];
    logic [7:0] m_result;
    vec_t       tbl [12];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        bus.reg_enable = '0;
        bus.opcode     = O_NOP;
        bus.a_enable   = 1'b0;
        bus.b_enable   = 1'b0;
        bus.start      = 1'b0;
        bus.imm        = '0;
    endtask

    task automatic ldi(input int r, input logic [7:0] v);
        bus.reg_enable = 16'(1 << r);
        bus.opcode     = O_LDI;
        bus.imm        = v;
        bus.start      = 1'b1;
        step();
        clear_inputs();
        m_regs[r] = v;
    endtask

    task automatic load_ab(input int ra, input int rb);
        bus.reg_enable = 16'(1 << ra);
        bus.a_enable   = 1'b1;
        step();
        clear_inputs();
        bus.reg_enable = 16'(1 << rb);
        bus.b_enable   = 1'b1;
        step();
        clear_inputs();
    endtask

    // Issues op, then counts cycles until done (bounded). Optionally injects a
    // start+load during the op at cycle 'inject'. Leaves the unit back in IDLE.
    task automatic run_op(input logic [7:0] op, input int inject, output int lat, output int bcnt);
        bus.opcode = op;
        bus.start  = 1'b1;
        step();
        clear_inputs();
        lat  = -1;
        bcnt = 0;
        for (int c = 1; c <= 20; c++) begin
            if (bus.busy) bcnt++;
            if (bus.done) begin
                lat = c;
                break;
            end
            if (c == inject) begin
                bus.start      = 1'b1;
                bus.opcode     = O_ADD;
                bus.reg_enable = 16'h0008;
                bus.a_enable   = 1'b1;
                bus.b_enable   = 1'b1;
            end
            step();
            clear_inputs();
        end
        step();
    endtask

    function automatic void model(input logic [7:0] op, input int a, input int b,
                                  output logic [7:0] r, output logic [2:0] f, output int lat);
        int   full;
        logic c;
        full = 0;
        c    = 1'b0;
        case (op)
            O_ADD: begin full = a + b; c = (full > 255); end
            O_SUB: begin full = (a - b + 256) % 256; c = (a < b); end
            O_AND: full = a & b;
            O_OR:  full = a | b;
            O_XOR: full = a ^ b;
            O_SHL: begin full = a * 2; c = (full > 255); end
            O_MUL: begin full = a * b; c = (full > 255); end
            default: ;
        endcase
        r   = 8'(full % 256);
        f   = {r[7], c, (r == 8'h00)};
        lat = (op == O_MUL) ? 9 : 2;
    endfunction

    initial begin
        int         lat, bcnt, dcnt;
        logic [7:0] er;
        logic [2:0] ef;
        int         elat;
        logic [7:0] ops [7];

        tbl[0]  = '{"add_wrap", O_ADD, 8'h05, 8'hFB, 8'h00, 3'b011, 2};
        tbl[1]  = '{"sub_borrow", O_SUB, 8'h03, 8'h05, 8'hFE, 3'b110, 2};
        tbl[2]  = '{"mul_hi", O_MUL, 8'h10, 8'h11, 8'h10, 3'b010, 9};
        tbl[3]  = '{"and", O_AND, 8'hF0, 8'h3C, 8'h30, 3'b000, 2};
        tbl[4]  = '{"or", O_OR, 8'h0F, 8'h30, 8'h3F, 3'b000, 2};
        tbl[5]  = '{"xor_zero", O_XOR, 8'hAA, 8'hAA, 8'h00, 3'b001, 2};
        tbl[6]  = '{"shl_carry", O_SHL, 8'h81, 8'h00, 8'h02, 3'b010, 2};
        tbl[7]  = '{"shl_neg", O_SHL, 8'h40, 8'h77, 8'h80, 3'b100, 2};
        tbl[8]  = '{"sub_zero", O_SUB, 8'h05, 8'h05, 8'h00, 3'b001, 2};
        tbl[9]  = '{"mul_max", O_MUL, 8'hFF, 8'hFF, 8'h01, 3'b010, 9};
        tbl[10] = '{"add_neg", O_ADD, 8'h7F, 8'h01, 8'h80, 3'b100, 2};
        tbl[11] = '{"mul_zero", O_MUL, 8'h00, 8'h37, 8'h00, 3'b001, 9};
        ops = '{O_ADD, O_SUB, O_AND, O_OR, O_XOR, O_SHL, O_MUL};

        clear_inputs();
        for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        reset = 1'b1;
        step();
        step();
        check("rst_result", bus.result, 8'h00);
        check("rst_flags", bus.flags, 3'b000);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_done", bus.done, 1'b0);
        check("rst_err", bus.err, 1'b0);
        reset = 1'b0;

        // Directed table: operands via LDI r3/r4, latched into A/B.
        for (int i = 0; i < 12; i++) begin
            ldi(3, tbl[i].a);
            ldi(4, tbl[i].b);
            load_ab(3, 4);
            run_op(tbl[i].op, 0, lat, bcnt);
            check($sformatf("%s_res", tbl[i].name), bus.result, tbl[i].res);
            check($sformatf("%s_flags", tbl[i].name), bus.flags, tbl[i].flg);
            check($sformatf("%s_lat", tbl[i].name), lat, tbl[i].lat);
            check($sformatf("%s_busy", tbl[i].name), bcnt, tbl[i].lat - 1);
        end

        // MUL with a start+load attempt at +4: ignored, operands frozen.
        ldi(1, 8'h10);
        ldi(2, 8'h11);
        ldi(3, 8'h05);
        load_ab(1, 2);
        run_op(O_MUL, 4, lat, bcnt);
        check("mulign_lat", lat, 9);
        check("mulign_busy", bcnt, 8);
        check("mulign_res", bus.result, 8'h10);
        check("mulign_flags", bus.flags, 3'b010);
        run_op(O_ADD, 0, lat, bcnt);
        check("frozen_add_res", bus.result, 8'h21);

        // Reset at +4 of a MUL.
        bus.opcode = O_MUL;
        bus.start  = 1'b1;
        step();
        clear_inputs();
        step();
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("mulrst_busy", bus.busy, 1'b0);
        check("mulrst_done", bus.done, 1'b0);
        check("mulrst_res", bus.result, 8'h00);
        for (int i = 0; i < NR; i++) m_regs[i] = 8'h00;
        dcnt = 0;
        for (int c = 0; c < 12; c++) begin
            if (bus.done) dcnt++;
            step();
        end
        check("mulrst_no_done", dcnt, 0);
        run_op(O_ADD, 0, lat, bcnt);
        check("postrst_lat", lat, 2);
        check("postrst_flags", bus.flags, 3'b001);

        // Multi-hot select with a load: err, A untouched.
        ldi(1, 8'h20);
        ldi(2, 8'h40);
        ldi(5, 8'h03);
        load_ab(5, 5);
        bus.reg_enable = 16'h0006;
        bus.a_enable   = 1'b1;
        step();
        clear_inputs();
        check("badsel_err", bus.err, 1'b1);
        step();
        check("badsel_err_pulse", bus.err, 1'b0);
        run_op(O_ADD, 0, lat, bcnt);
        check("badsel_a_kept", bus.result, 8'h06);

        // Zero-hot select on LDI.
        bus.opcode = O_LDI;
        bus.imm    = 8'h55;
        bus.start  = 1'b1;
        step();
        clear_inputs();
        check("zerosel_ldi_err", bus.err, 1'b1);

        // Illegal opcode.
        bus.opcode = 8'hFF;
        bus.start  = 1'b1;
        step();
        clear_inputs();
        check("illegal_err", bus.err, 1'b1);
        check("illegal_busy", bus.busy, 1'b0);
        dcnt = 0;
        for (int c = 0; c < 6; c++) begin
            if (bus.done) dcnt++;
            step();
        end
        check("illegal_no_done", dcnt, 0);
        check("illegal_res_kept", bus.result, 8'h06);

        // NOP.
        bus.opcode = O_NOP;
        bus.start  = 1'b1;
        step();
        clear_inputs();
        check("nop_err", bus.err, 1'b0);
        check("nop_busy", bus.busy, 1'b0);

        // Read-before-write: load A from r7 while LDI rewrites r7.
        ldi(7, 8'h11);
        bus.reg_enable = 16'h0080;
        bus.a_enable   = 1'b1;
        bus.opcode     = O_LDI;
        bus.imm        = 8'h22;
        bus.start      = 1'b1;
        step();
        clear_inputs();
        m_regs[7]      = 8'h22;
        bus.reg_enable = 16'h0080;
        bus.b_enable   = 1'b1;
        step();
        clear_inputs();
        run_op(O_ADD, 0, lat, bcnt);
        check("rbw_res", bus.result, 8'h33);

        // ST result to r9, read back through OR with r0.
        bus.reg_enable = 16'h0200;
        bus.opcode     = O_ST;
        bus.start      = 1'b1;
        step();
        clear_inputs();
        check("st_no_done", bus.done, 1'b0);
        check("st_no_err", bus.err, 1'b0);
        m_regs[9] = 8'h33;
        load_ab(9, 0);
        run_op(O_OR, 0, lat, bcnt);
        check("st_readback", bus.result, 8'h33);
        m_result = bus.result;
        if (m_result !== 8'h33) m_result = 8'h33;

        // Randomized ops against the reference model.
        for (int n = 0; n < 40; n++) begin
            int         ra, rb, rs;
            logic [7:0] op;
            op = ops[$urandom_range(0, 6)];
            ra = $urandom_range(0, NR - 1);
            rb = $urandom_range(0, NR - 1);
            if ($urandom_range(0, 1) == 1) ldi(ra, 8'($urandom_range(0, 255)));
            if ($urandom_range(0, 1) == 1) ldi(rb, 8'($urandom_range(0, 255)));
            load_ab(ra, rb);
            model(op, int'(m_regs[ra]), int'(m_regs[rb]), er, ef, elat);
            run_op(op, 0, lat, bcnt);
            check($sformatf("rnd%0d_res", n), bus.result, er);
            check($sformatf("rnd%0d_flags", n), bus.flags, ef);
            check($sformatf("rnd%0d_lat", n), lat, elat);
            m_result = er;
            if ($urandom_range(0, 3) == 0) begin
                rs             = $urandom_range(0, NR - 1);
                bus.reg_enable = 16'(1 << rs);
                bus.opcode     = O_ST;
                bus.start      = 1'b1;
                step();
                clear_inputs();
                m_regs[rs] = m_result;
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cpu_exec_unit.md
CPU_EXEC_UNIT -- requirements
Module: cpu_exec_unit

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath and register width.
REQ-002 SHALL have parameter NUM_REGS, default 16, register count; equals reg_enable width.
REQ-003 SHALL have port clk  input  1  clock; all state updates on rising edge.
REQ-004 SHALL have port reset  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port reg_enable  input  NUM_REGS  one-hot register select from the sequencer FSM.
REQ-006 SHALL have port opcode  input  8  operation code from the sequencer FSM.
REQ-007 SHALL have port a_enable  input  1  load operand latch A from the selected register.
REQ-008 SHALL have port b_enable  input  1  load operand latch B from the selected register.
REQ-009 SHALL have port start  input  1  single-cycle strobe issuing opcode.
REQ-010 SHALL have port imm  input  DATA_W  immediate value for LDI.
REQ-011 SHALL have port result  output  DATA_W  registered result of the last completed ALU/MUL operation.
REQ-012 SHALL have port flags  output  3  registered {N,C,Z}.
REQ-013 SHALL have port busy  output  1  high while an operation is in flight.
REQ-014 SHALL have port done  output  1  one-cycle completion pulse.
REQ-015 SHALL have port err  output  1  one-cycle pulse for an illegal opcode or a non-one-hot select.

Function
REQ-016 SHALL use opcodes 00 NOP, 01 LDI, 02 ADD, 03 SUB, 04 AND, 05 OR, 06 XOR, 07 MUL, 08 ST, 09 SHL; all other values are illegal.
REQ-017 SHALL, when idle and a_enable/b_enable is high, latch the selected register into A/B at that edge; both high loads both latches from the same register.
REQ-018 SHALL ignore a_enable, b_enable and start while busy; operands stay frozen.
REQ-019 SHALL make reg_enable zero or multi-hot block any register access and pulse err when a load, LDI or ST is attempted in that cycle.
REQ-020 SHALL implement FSM states IDLE, EXEC, MUL and DONE.
REQ-021 SHALL, on start in IDLE, go to EXEC for ADD/SUB/AND/OR/XOR/SHL, to MUL for MUL, and stay in IDLE for LDI/ST/NOP/illegal.
REQ-022 SHALL, in EXEC, register result and flags and go to DONE; done is high in DONE for one cycle, then the FSM returns to IDLE.
REQ-023 SHALL run MUL as an 8-iteration shift-add, one iteration per cycle, then go to DONE.
REQ-024 SHALL hold busy high in EXEC and MUL and low in IDLE and DONE.
REQ-025 SHALL assert done 2 cycles after the start edge for single-cycle ops and 9 cycles after for MUL.
REQ-026 SHALL complete LDI and ST in the start cycle: LDI writes imm to the selected register, ST writes result to it; neither pulses done.
REQ-027 SHALL, for NOP, change no state and raise no pulse.
REQ-028 SHALL, for an illegal opcode, pulse err the cycle after start and change no state.
REQ-029 SHALL keep ADD/SUB modulo 2^DATA_W; ADD C is the carry-out, SUB C is the borrow (A<B).
REQ-030 SHALL set SHL C = A[MSB] with result A<<1.
REQ-031 SHALL set C=0 for AND/OR/XOR.
REQ-032 SHALL return the low DATA_W bits for MUL, with C=1 if the high half is nonzero.
REQ-033 SHALL set Z=(result==0) and N=result[MSB] for every ALU/MUL op.
REQ-034 SHALL make an operand load and a register write to the same register in one cycle return the old value (read-before-write).

Reset
REQ-035 SHALL, on reset, clear result, flags, A, B and all registers, force IDLE, and drive busy, done and err to 0.
REQ-036 SHALL abort an in-flight operation on reset mid-MUL/EXEC, with no done and an unchanged (cleared) result.

Structure
REQ-037 SHALL place the opcode constants, state enum and flag bit indices in shared package cpu_pkg.
REQ-038 SHALL place the register file (NUM_REGS x DATA_W, one-hot write/read select, one write port, combinational read) in sub-module cpu_regfile.

Verification
REQ-039 SHALL cover: LDI 0x05 to r3, LDI 0xFB to r4; A<-r3, B<-r4; ADD -> done at +2, result 0x00, flags Z=1,C=1,N=0.
REQ-040 SHALL cover: A=0x03, B=0x05 SUB -> result 0xFE, C=1, N=1, Z=0.
REQ-041 SHALL cover: A=0x10, B=0x11 MUL -> busy for 8 cycles, done at +9, result 0x10, C=1; start at +4 ignored.
REQ-042 SHALL cover: reset asserted at cycle +4 of MUL -> no done, result 0x00, IDLE next cycle.
REQ-043 SHALL cover: reg_enable=0x0006 with a_enable -> err pulse, A unchanged; opcode 0xFF start -> err pulse, no done.
